// File: rtl/serial_deser_rx_if.sv
// Serial link receive bundle: per-channel data/valid in, reassembled frame and status out.
// The receiver takes the slave view; the upstream serializer or a bench takes the master view.
interface serial_deser_rx_if #(
    parameter int DATA_W = 128,
    parameter int CH_NUM = 8,
    parameter int CNT_W  = 16
);
    logic [CH_NUM-1:0] data_in_ch;
    logic [CH_NUM-1:0] vld_in_ch;
    logic [DATA_W-1:0] data_gray_out;
    logic [CH_NUM-1:0] ch_onehot;
    logic [CNT_W-1:0]  bit_count;
    logic              frame_done;
    logic              ovf_err;
    logic              coll_err;
    logic              chan_err;
    logic              busy;
    logic [15:0]       crc_out;

    modport master (
        output data_in_ch, vld_in_ch,
        input  data_gray_out, ch_onehot, bit_count, frame_done,
               ovf_err, coll_err, chan_err, busy, crc_out
    );

    modport slave (
        input  data_in_ch, vld_in_ch,
        output data_gray_out, ch_onehot, bit_count, frame_done,
               ovf_err, coll_err, chan_err, busy, crc_out
    );
endinterface

// File: rtl/serial_deser_rx.sv
// Locks onto the single channel raising valid and rebuilds its MSB-first frame, left-aligned.
// Optional RX_CRC16_EN adds a CRC-16/CCITT-FALSE over every counted bit; otherwise crc_out is 0.
module serial_deser_rx #(
    parameter int DATA_W = 128,
    parameter int CH_NUM = 8,
    parameter int CNT_W  = 16
) (
    input  logic               clk_out16x,
    input  logic               rst,
    serial_deser_rx_if.slave   bus
);
    localparam int              IDX_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] DATA_W_C = CNT_W'(DATA_W);

    typedef enum logic {IDLE, RECV} state_t;

    state_t            state_q, state_d;
    logic [CH_NUM-1:0] ch_q, ch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              ovf_q, ovf_d;
    logic              coll_q, coll_d;

    logic [DATA_W-1:0] dout_q, dout_d;
    logic [CH_NUM-1:0] chout_q, chout_d;
    logic [CNT_W-1:0]  bcnt_q, bcnt_d;
    logic              ovfo_q, ovfo_d;
    logic              collo_q, collo_d;
    logic              done_q, done_d;
    logic              chan_err_q, chan_err_d;

    logic              vld_onehot;
    logic              start_bit;
    logic              lock_vld;
    logic              lock_bit;
    logic              other_vld;
    logic [IDX_W-1:0]  wr_idx;

    assign vld_onehot = (bus.vld_in_ch != '0) &&
                        ((bus.vld_in_ch & (bus.vld_in_ch - CH_NUM'(1))) == '0);
    assign start_bit  = |(bus.data_in_ch & bus.vld_in_ch);
    assign lock_vld   = |(bus.vld_in_ch & ch_q);
    assign lock_bit   = |(bus.data_in_ch & ch_q);
    assign other_vld  = |(bus.vld_in_ch & ~ch_q);
    // Count n maps to word position DATA_W-1-n; only used while n < DATA_W.
    assign wr_idx     = IDX_W'(DATA_W - 1) - cnt_q[IDX_W-1:0];

`ifdef RX_CRC16_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] crc_out_q, crc_out_d;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        word_d     = word_q;
        ovf_d      = ovf_q;
        coll_d     = coll_q;
        dout_d     = dout_q;
        chout_d    = chout_q;
        bcnt_d     = bcnt_q;
        ovfo_d     = ovfo_q;
        collo_d    = collo_q;
        done_d     = 1'b0;
        chan_err_d = 1'b0;
`ifdef RX_CRC16_EN
        crc_d      = crc_q;
        crc_out_d  = crc_out_q;
`endif
        case (state_q)
            IDLE: begin
                if (vld_onehot) begin
                    ch_d               = bus.vld_in_ch;
                    word_d             = '0;
                    word_d[DATA_W-1]   = start_bit;
                    cnt_d              = CNT_W'(1);
                    ovf_d              = 1'b0;
                    coll_d             = 1'b0;
                    state_d            = RECV;
`ifdef RX_CRC16_EN
                    crc_d              = crc_step(16'hFFFF, start_bit);
`endif
                end else if (bus.vld_in_ch != '0) begin
                    chan_err_d = 1'b1;
                end
            end
            RECV: begin
                if (other_vld) coll_d = 1'b1;
                if (lock_vld) begin
                    if (cnt_q < DATA_W_C) word_d[wr_idx] = lock_bit;
                    else                  ovf_d          = 1'b1;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
`ifdef RX_CRC16_EN
                    crc_d = crc_step(crc_q, lock_bit);
`endif
                end else begin
                    // Locked valid dropped: publish the frame; the other-channel check of
                    // this last RECV cycle still counts toward the collision flag.
                    dout_d  = word_q;
                    chout_d = ch_q;
                    bcnt_d  = cnt_q;
                    ovfo_d  = ovf_q;
                    collo_d = coll_q | other_vld;
                    done_d  = 1'b1;
                    state_d = IDLE;
`ifdef RX_CRC16_EN
                    crc_out_d = crc_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_out16x or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            ovf_q      <= 1'b0;
            coll_q     <= 1'b0;
            dout_q     <= '0;
            chout_q    <= '0;
            bcnt_q     <= '0;
            ovfo_q     <= 1'b0;
            collo_q    <= 1'b0;
            done_q     <= 1'b0;
            chan_err_q <= 1'b0;
`ifdef RX_CRC16_EN
            crc_q      <= '0;
            crc_out_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            ovf_q      <= ovf_d;
            coll_q     <= coll_d;
            dout_q     <= dout_d;
            chout_q    <= chout_d;
            bcnt_q     <= bcnt_d;
            ovfo_q     <= ovfo_d;
            collo_q    <= collo_d;
            done_q     <= done_d;
            chan_err_q <= chan_err_d;
`ifdef RX_CRC16_EN
            crc_q      <= crc_d;
            crc_out_q  <= crc_out_d;
`endif
        end
    end

    assign bus.data_gray_out = dout_q;
    assign bus.ch_onehot     = chout_q;
    assign bus.bit_count     = bcnt_q;
    assign bus.frame_done    = done_q;
    assign bus.ovf_err       = ovfo_q;
    assign bus.coll_err      = collo_q;
    assign bus.chan_err      = chan_err_q;
    assign bus.busy          = (state_q == RECV);
`ifdef RX_CRC16_EN
    assign bus.crc_out       = crc_out_q;
`else
    assign bus.crc_out       = 16'h0000;
`endif
endmodule

// File: tb/tb_serial_deser_rx.sv
// Bench for serial_deser_rx: frame-level reference model plus per-cycle output comparison.
// Expected CRC follows RX_CRC16_EN the same way the design does.
module tb_serial_deser_rx;
    localparam int DATA_W = 128;
    localparam int CH_NUM = 8;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_deser_rx_if #(.DATA_W(DATA_W), .CH_NUM(CH_NUM), .CNT_W(CNT_W)) bus ();

    serial_deser_rx #(.DATA_W(DATA_W), .CH_NUM(CH_NUM), .CNT_W(CNT_W)) dut (
        .clk_out16x (clk),
        .rst        (rst),
        .bus        (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] exp_word;
    logic [7:0]        exp_ch;
    logic [15:0]       exp_cnt;
    logic              exp_ovf, exp_coll, exp_done, exp_chan_err, exp_busy;
    logic [15:0]       exp_crc;
    bit                fbits [0:511];
    int                busy_cycles, done_cycles;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic clear_exp();
        exp_word = '0; exp_ch = '0; exp_cnt = '0; exp_ovf = 0; exp_coll = 0;
        exp_done = 0; exp_chan_err = 0; exp_busy = 0; exp_crc = '0;
    endtask

    always @(negedge clk) begin
        chk("busy",       bus.busy,          exp_busy);
        chk("frame_done", bus.frame_done,    exp_done);
        chk("chan_err",   bus.chan_err,      exp_chan_err);
        chk("data",       bus.data_gray_out, exp_word);
        chk("ch_onehot",  bus.ch_onehot,     exp_ch);
        chk("bit_count",  bus.bit_count,     exp_cnt);
        chk("ovf_err",    bus.ovf_err,       exp_ovf);
        chk("coll_err",   bus.coll_err,      exp_coll);
        chk("crc_out",    bus.crc_out,       exp_crc);
        if (bus.busy)       busy_cycles++;
        if (bus.frame_done) done_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v, input logic [7:0] d);
        bus.vld_in_ch  = v;
        bus.data_in_ch = d;
    endtask

    // Frame-level model: word is the first DATA_W bits MSB-first, zero-filled.
    task automatic model_frame(input int c, input int n, input bit coll);
        logic [15:0] crc;
        exp_word = '0;
        for (int i = 0; i < n && i < DATA_W; i++) exp_word[DATA_W-1-i] = fbits[i];
        exp_ch   = 8'(1) << c;
        exp_cnt  = 16'(n);
        exp_ovf  = (n > DATA_W);
        exp_coll = coll;
        crc = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            if (crc[15] ^ fbits[i]) crc = {crc[14:0], 1'b0} ^ 16'h1021;
            else                    crc = {crc[14:0], 1'b0};
        end
`ifdef RX_CRC16_EN
        exp_crc = crc;
`else
        exp_crc = 16'h0000;
`endif
    endtask

    task automatic send_bits(input int c, input int n, input int coll_at, input int coll_ch);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            logic [7:0] v;
            d = 8'($urandom);
            d[c] = fbits[i];
            v = 8'(1) << c;
            if (i == coll_at) v[coll_ch] = 1'b1;
            drive(v, d);
            tick();
            exp_busy = 1; exp_chan_err = 0; exp_done = 0;
        end
    endtask

    task automatic end_frame(input int c, input int n, input bit coll);
        drive(8'h00, 8'($urandom));
        tick();
        model_frame(c, n, coll);
        exp_busy = 0; exp_done = 1;
        drive(8'h00, 8'($urandom));
        tick();
        exp_done = 0;
    endtask

    task automatic frame(input int c, input int n, input int coll_at, input int coll_ch);
        $display("[TB] frame ch=%0d bits=%0d coll_at=%0d", c + 1, n, coll_at);
        send_bits(c, n, coll_at, coll_ch);
        end_frame(c, n, coll_at >= 1 && coll_at < n);
    endtask

    task automatic chan_err_pulse(input logic [7:0] v);
        $display("[TB] non-one-hot valid %h in IDLE", v);
        drive(v, 8'($urandom));
        tick();
        exp_chan_err = 1;
        drive(8'h00, 8'($urandom));
        tick();
        exp_chan_err = 0;
    endtask

    task automatic rand_bits(input int n);
        for (int i = 0; i < n; i++) fbits[i] = bit'($urandom_range(0, 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        string s;
        byte   b;
        clear_exp();
        drive(8'h00, 8'h00);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // 1: ch3, 128 bits of repeating A5
        for (int i = 0; i < 128; i++) begin
            b = 8'hA5;
            fbits[i] = b[7 - (i % 8)];
        end
        frame(2, 128, -1, 0);
        chk("t1_word", bus.data_gray_out, {16{8'hA5}});
        chk("t1_ch",   bus.ch_onehot, 8'h04);
        chk("t1_cnt",  bus.bit_count, 16'd128);
        chk("t1_errs", {bus.ovf_err, bus.coll_err}, 2'b00);

        // 2: ch1, 16'hBEEF; busy for 16 cycles, one done strobe
        for (int i = 0; i < 16; i++) begin
            logic [15:0] w;
            w = 16'hBEEF;
            fbits[i] = w[15 - i];
        end
        busy_cycles = 0; done_cycles = 0;
        frame(0, 16, -1, 0);
        chk("t2_word",  bus.data_gray_out, {16'hBEEF, 112'd0});
        chk("t2_cnt",   bus.bit_count, 16'd16);
        chk("t2_busy",  DATA_W'(busy_cycles), DATA_W'(16));
        chk("t2_done",  DATA_W'(done_cycles), DATA_W'(1));

        // 3: ch8, 130 bits -> overflow
        rand_bits(130);
        frame(7, 130, -1, 0);
        chk("t3_ovf", bus.ovf_err, 1'b1);
        chk("t3_cnt", bus.bit_count, 16'd130);
        chk("t3_ch",  bus.ch_onehot, 8'h80);

        // 4: chan_err then ch2 frame with ch5 valid at bit 10
        chan_err_pulse(8'h03);
        rand_bits(24);
        frame(1, 24, 10, 4);
        chk("t4_coll", bus.coll_err, 1'b1);
        chk("t4_ch",   bus.ch_onehot, 8'h02);

        // 5: reset at bit 40 of a ch4 frame, then 32-bit ch6 frame
        rand_bits(40);
        $display("[TB] ch4 frame aborted by reset after 40 bits");
        done_cycles = 0;
        send_bits(3, 40, -1, 0);
        rst = 1'b1;
        clear_exp();
        drive(8'h00, 8'h00);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("t5_nodone", DATA_W'(done_cycles), DATA_W'(0));
        rand_bits(32);
        frame(5, 32, -1, 0);
        chk("t5_cnt", bus.bit_count, 16'd32);
        chk("t5_ch",  bus.ch_onehot, 8'h20);

        // 6: "123456789" on ch1
        s = "123456789";
        for (int k = 0; k < 9; k++) begin
            b = s[k];
            for (int j = 0; j < 8; j++) fbits[k*8 + j] = b[7 - j];
        end
        frame(0, 72, -1, 0);
        chk("t6_cnt",  bus.bit_count, 16'd72);
        chk("t6_word", bus.data_gray_out, {72'h313233343536373839, 56'd0});
`ifdef RX_CRC16_EN
        chk("t6_crc", bus.crc_out, 16'h29B1);
`else
        chk("t6_crc", bus.crc_out, 16'h0000);
`endif

        // Randomized frames with occasional collisions, channel errors and idle gaps
        for (int f = 0; f < 25; f++) begin
            int c, n, coll_at, coll_ch;
            c = $urandom_range(0, 7);
            n = $urandom_range(1, 140);
            coll_at = -1;
            coll_ch = 0;
            if (n >= 2 && $urandom_range(0, 2) == 0) begin
                coll_at = $urandom_range(1, n - 1);
                coll_ch = (c + $urandom_range(1, 7)) % 8;
            end
            rand_bits(n);
            frame(c, n, coll_at, coll_ch);
            if ($urandom_range(0, 3) == 0) begin
                logic [7:0] v;
                v = 8'($urandom);
                while ($countones(v) < 2) v = 8'($urandom);
                chan_err_pulse(v);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
